// File: rtl/mul_sequencer_pkg.sv
// Shared CPU constants for the multi-cycle multiply sequencer: default width,
// multiply ALU code, FSM state encoding and the qualified-start helper.
package mul_sequencer_pkg;

  localparam int unsigned WIDTH_DEF    = 32;
  localparam logic [2:0]  MUL_CODE_DEF = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // A multiply may only begin when the EX instruction is a valid, unflushed MUL.
  function automatic logic is_qs(input logic       start,
                                 input logic [2:0] alu_ctrl,
                                 input logic [2:0] mul_code,
                                 input logic       flush);
    return start && (alu_ctrl == mul_code) && !flush;
  endfunction

endpackage

// File: rtl/mul_sequencer_if.sv
// Pipeline-facing bundle of the multiply sequencer: EX-stage request and
// operands in, stall/busy/valid/result out.
interface mul_sequencer_if #(
  parameter int unsigned WIDTH = 32
);

  logic             start_i;
  logic [2:0]       ALU_Ctrl_i;
  logic             flush_i;
  logic [WIDTH-1:0] data1_i;
  logic [WIDTH-1:0] data2_i;
  logic             stall_o;
  logic             busy_o;
  logic             valid_o;
  logic [WIDTH-1:0] result_o;

  modport master (
    output start_i, ALU_Ctrl_i, flush_i, data1_i, data2_i,
    input  stall_o, busy_o, valid_o, result_o
  );

  modport slave (
    input  start_i, ALU_Ctrl_i, flush_i, data1_i, data2_i,
    output stall_o, busy_o, valid_o, result_o
  );

endinterface

// File: rtl/mul_datapath.sv
// Shift-and-add multiply datapath: operand shift registers, accumulator and
// iteration counter; one partial product per step.
module mul_datapath #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  output logic             last_c,
  output logic [WIDTH-1:0] acc
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [CNT_W-1:0] cnt;

  // Final iteration: the step taken on this edge completes the product.
  assign last_c = (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (load) begin
      mcand  <= data1;
      mplier <= data2;
      acc    <= '0;
      cnt    <= '0;
    end else if (step) begin
      if (mplier[0]) begin
        acc <= acc + mcand;
      end
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mul_sequencer.sv
// Multi-cycle multiply sequencer: stalls the front of the pipeline for a fixed
// WIDTH+1 cycles and presents the low WIDTH product bits for one cycle.
module mul_sequencer
  import mul_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH    = WIDTH_DEF,
  parameter logic [2:0]  MUL_CODE = MUL_CODE_DEF
) (
  input  logic            clk_i,
  input  logic            rst_i,
  mul_sequencer_if.slave  bus
);

  state_e           state_q;
  state_e           state_d;
  logic             qs;
  logic             load;
  logic             step;
  logic             last_c;
  logic             in_idle;
  logic [WIDTH-1:0] acc;

  assign qs = is_qs(bus.start_i, bus.ALU_Ctrl_i, MUL_CODE, bus.flush_i);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state; the unused 2'b11 encoding falls into the IDLE branch.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    case (state_q)
      ST_BUSY: begin
        step = 1'b1;
        if (bus.flush_i) begin
          state_d = ST_IDLE;
        end else if (last_c) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        if (qs) begin
          load    = 1'b1;
          state_d = ST_BUSY;
        end
      end
    endcase
  end

  mul_datapath #(
    .WIDTH (WIDTH)
  ) u_datapath (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load   (load),
    .step   (step),
    .data1  (bus.data1_i),
    .data2  (bus.data2_i),
    .last_c (last_c),
    .acc    (acc)
  );

  // Stall must cover the request cycle itself, so it is decoded from inputs;
  // gating with rst_i keeps it low while reset is held.
  always_comb begin
    in_idle      = (state_q != ST_BUSY) && (state_q != ST_DONE);
    bus.busy_o   = (state_q == ST_BUSY);
    bus.valid_o  = (state_q == ST_DONE);
    bus.result_o = (state_q == ST_DONE) ? acc : '0;
    bus.stall_o  = rst_i && ((in_idle && qs) || ((state_q == ST_BUSY) && !bus.flush_i));
  end

endmodule

// File: tb/tb_mul_sequencer.sv
// Directed plus randomized bench for mul_sequencer against a cycle-count and
// modulo-product reference model.
module tb_mul_sequencer;

  localparam int unsigned W   = 32;
  localparam logic [2:0]  MUL = 3'b111;
  localparam int          LAT = W + 1;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  mul_sequencer_if #(.WIDTH(W)) bus();

  mul_sequencer #(
    .WIDTH    (W),
    .MUL_CODE (MUL)
  ) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic s, input logic [2:0] c, input logic f,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    bus.start_i    = s;
    bus.ALU_Ctrl_i = c;
    bus.flush_i    = f;
    bus.data1_i    = a;
    bus.data2_i    = b;
  endtask

  function automatic logic [W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] p;
    p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    return p[W-1:0];
  endfunction

  // One multiply: qs on cycle 0, noisy operands and ignored starts afterwards.
  task automatic do_mul(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
    int stall_n = 0, valid_n = 0, valid_at = -1, first_low = -1, stray = 0;
    logic [W-1:0] res = '0;
    for (int i = 0; i < LAT + 8; i++) begin
      @(negedge clk);
      if (i == 0) drive(1'b1, MUL, 1'b0, a, b);
      else        drive(i <= LAT, MUL, 1'b0, $urandom, $urandom);
      #1;
      if (bus.stall_o) stall_n++;
      else if (first_low < 0) first_low = i;
      if (bus.valid_o) begin valid_n++; valid_at = i; res = bus.result_o; end
      else if (bus.result_o !== '0) stray++;
    end
    drive(1'b0, 3'b000, 1'b0, '0, '0);
    check({tag, " stall_cycles"}, 64'(stall_n), 64'(LAT));
    check({tag, " stall_drop_at"}, 64'(first_low), 64'(LAT));
    check({tag, " valid_pulses"}, 64'(valid_n), 64'd1);
    check({tag, " valid_at"}, 64'(valid_at), 64'(LAT));
    check({tag, " result"}, 64'(res), 64'(ref_mul(a, b)));
    check({tag, " result_zero_outside"}, 64'(stray), 64'd0);
  endtask

  task automatic non_mul(input string tag, input logic [2:0] code);
    int active = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive(1'b1, code, 1'b0, $urandom, $urandom);
      #1;
      if (bus.stall_o || bus.busy_o || bus.valid_o) active++;
    end
    drive(1'b0, 3'b000, 1'b0, '0, '0);
    check({tag, " no_activity"}, 64'(active), 64'd0);
  endtask

  initial begin
    int valid_cnt, busy_cnt;
    int vat[$];
    logic [W-1:0] vres[$];
    logic [W-1:0] ra, rb;

    // Reset with a live MUL request: everything held low.
    rst_n = 1'b0;
    drive(1'b1, MUL, 1'b0, 32'd7, 32'd6);
    #1;
    check("reset_outputs", 64'({bus.stall_o, bus.busy_o, bus.valid_o, bus.result_o}), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 3'b000, 1'b0, '0, '0);
    @(negedge clk);

    do_mul("7x6", 32'd7, 32'd6);
    do_mul("ffffffff_x2", 32'hFFFF_FFFF, 32'd2);
    do_mul("0x1234", 32'd0, 32'h1234);
    do_mul("neg3x5", 32'hFFFF_FFFD, 32'd5);
    non_mul("alu010", 3'b010);

    // Flush in the 10th BUSY cycle.
    valid_cnt = 0;
    for (int i = 0; i < LAT + 8; i++) begin
      @(negedge clk);
      if (i == 0)       drive(1'b1, MUL, 1'b0, 32'd9, 32'd9);
      else if (i == 10) drive(1'b0, MUL, 1'b1, $urandom, $urandom);
      else              drive(1'b0, MUL, 1'b0, $urandom, $urandom);
      #1;
      if (i == 10) begin
        check("flush_cycle_stall", 64'(bus.stall_o), 64'd0);
        check("flush_cycle_busy", 64'(bus.busy_o), 64'd1);
      end
      if (i == 11) check("after_flush_busy", 64'(bus.busy_o), 64'd0);
      if (bus.valid_o) valid_cnt++;
    end
    check("flush_no_valid", 64'(valid_cnt), 64'd0);

    // Start and flush together in IDLE must not start.
    @(negedge clk);
    drive(1'b1, MUL, 1'b1, 32'd3, 32'd3);
    #1;
    check("start_flush_stall", 64'(bus.stall_o), 64'd0);
    @(negedge clk);
    drive(1'b0, 3'b000, 1'b0, '0, '0);
    #1;
    check("start_flush_busy", 64'(bus.busy_o), 64'd0);

    // Reset in the 5th BUSY cycle.
    for (int i = 0; i <= 5; i++) begin
      @(negedge clk);
      if (i == 0) drive(1'b1, MUL, 1'b0, 32'd11, 32'd13);
      else        drive(1'b0, MUL, 1'b0, $urandom, $urandom);
      #1;
    end
    check("pre_reset_busy", 64'(bus.busy_o), 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid_reset_outputs", 64'({bus.stall_o, bus.busy_o, bus.valid_o, bus.result_o}), 64'd0);
    @(negedge clk);
    drive(1'b1, MUL, 1'b0, 32'd2, 32'd2);
    #1;
    check("reset_held_stall", 64'(bus.stall_o), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 3'b000, 1'b0, '0, '0);
    valid_cnt = 0;
    busy_cnt  = 0;
    for (int i = 0; i < LAT + 8; i++) begin
      @(negedge clk);
      #1;
      if (bus.valid_o) valid_cnt++;
      if (bus.busy_o)  busy_cnt++;
    end
    check("post_reset_no_valid", 64'(valid_cnt), 64'd0);
    check("post_reset_no_busy", 64'(busy_cnt), 64'd0);

    // Back-to-back: second qs in the IDLE cycle right after DONE.
    for (int i = 0; i < 2 * LAT + 10; i++) begin
      @(negedge clk);
      if (i == 0)            drive(1'b1, MUL, 1'b0, 32'd3, 32'd5);
      else if (i == LAT + 1) drive(1'b1, MUL, 1'b0, 32'd4, 32'd4);
      else                   drive(1'b0, MUL, 1'b0, $urandom, $urandom);
      #1;
      if (bus.valid_o) begin vat.push_back(i); vres.push_back(bus.result_o); end
    end
    drive(1'b0, 3'b000, 1'b0, '0, '0);
    check("b2b_pulses", 64'(vat.size()), 64'd2);
    check("b2b_first_at", 64'((vat.size() > 0) ? vat[0] : -1), 64'(LAT));
    check("b2b_second_at", 64'((vat.size() > 1) ? vat[1] : -1), 64'(2 * LAT + 1));
    check("b2b_first_res", 64'((vres.size() > 0) ? vres[0] : '1), 64'(ref_mul(32'd3, 32'd5)));
    check("b2b_second_res", 64'((vres.size() > 1) ? vres[1] : '1), 64'(ref_mul(32'd4, 32'd4)));

    // Randomized operands and non-multiply codes.
    for (int k = 0; k < 6; k++) begin
      ra = $urandom;
      rb = (k == 0) ? '0 : $urandom;
      do_mul($sformatf("rand%0d", k), ra, rb);
      non_mul($sformatf("rand_code%0d", k), 3'($urandom_range(0, 6)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
